// File: rtl/tt_um_jleugeri_ttt_event_scheduler.sv
// Event scheduler: snapshots a SIZE-bit event vector and emits the index of each
// set bit, lowest first, one per valid/ready handshake, then pulses done.
module tt_um_jleugeri_ttt_event_scheduler #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned IDX_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [SIZE-1:0]   pending;
    logic [SIZE-1:0]   pending_cleared;
    logic [IDX_W-1:0]  lsb_idx;
    logic              found;
    logic              handshake;

    // Lowest-set-bit search, driven from the snapshot register only.
    always_comb begin
        lsb_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (!found && pending[i]) begin
                lsb_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    // Subtracting one borrows through the trailing zeros, so the AND drops the lowest set bit.
    assign pending_cleared = pending & (pending - SIZE'(1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_idx   = out_valid ? lsb_idx : '0;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pending <= in_vec;
                        count   <= '0;
                        state   <= (in_vec != '0) ? SCAN : DONE;
                    end
                end
                SCAN: begin
                    if (handshake) begin
                        count <= count + 1'b1;
                    end
                    if (abort) begin
                        pending <= '0;
                        state   <= DONE;
                    end else if (handshake) begin
                        pending <= pending_cleared;
                        if (pending_cleared == '0) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_scheduler.sv
// Directed self-checking bench for the event scheduler (SIZE=16).
module tb_tt_um_jleugeri_ttt_event_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_vec = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_idx;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    tt_um_jleugeri_ttt_event_scheduler #(.SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .abort(abort), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] v);
        in_vec   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL reset_out_idx got %0d exp 0", out_idx); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy got %0b%0b exp 00", done, busy); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero_vector();
        accept(16'h0000);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %0b exp 1", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid got %0b exp 0", out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL zero_count got %0d exp 0", count); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL zero_busy_ready got %0b%0b exp 10", busy, in_ready); end
        step();
        checks++; if (done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL zero_after got done=%0b rdy=%0b exp 0 1", done, in_ready); end
    endtask

    task automatic test_sparse();
        logic [3:0] exp_idx [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
        out_ready = 1'b1;
        accept(16'h8421);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_idx !== exp_idx[i]) begin errors++; $display("FAIL sparse_idx%0d got v=%0b idx=%0d exp v=1 idx=%0d", i, out_valid, out_idx, exp_idx[i]); end
            step();
        end
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL sparse_done got done=%0b v=%0b exp 1 0", done, out_valid); end
        checks++; if (count !== 5'd4) begin errors++; $display("FAIL sparse_count got %0d exp 4", count); end
        out_ready = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sparse_idle got rdy=%0b done=%0b exp 1 0", in_ready, done); end
        checks++; if (count !== 5'd4) begin errors++; $display("FAIL sparse_count_hold got %0d exp 4", count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        accept(16'h0006);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_idx !== 4'd1) begin errors++; $display("FAIL stall_hold%0d got v=%0b idx=%0d exp v=1 idx=1", i, out_valid, out_idx); end
            step();
        end
        out_ready = 1'b1;
        checks++; if (out_idx !== 4'd1) begin errors++; $display("FAIL stall_first got %0d exp 1", out_idx); end
        step();
        checks++; if (out_valid !== 1'b1 || out_idx !== 4'd2) begin errors++; $display("FAIL stall_second got v=%0b idx=%0d exp v=1 idx=2", out_valid, out_idx); end
        step();
        out_ready = 1'b0;
        checks++; if (done !== 1'b1 || count !== 5'd2) begin errors++; $display("FAIL stall_done got done=%0b count=%0d exp 1 2", done, count); end
        step();
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        accept(16'hFFFF);
        checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL abort_idx0 got %0d exp 0", out_idx); end
        step();
        checks++; if (out_idx !== 4'd1) begin errors++; $display("FAIL abort_idx1 got %0d exp 1", out_idx); end
        step();
        checks++; if (out_idx !== 4'd2) begin errors++; $display("FAIL abort_idx2 got %0d exp 2", out_idx); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_idx !== 4'd0) begin errors++; $display("FAIL abort_out got v=%0b idx=%0d exp 0 0", out_valid, out_idx); end
        checks++; if (done !== 1'b1 || count !== 5'd3) begin errors++; $display("FAIL abort_done got done=%0b count=%0d exp 1 3", done, count); end
        step();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got rdy=%0b busy=%0b exp 1 0", in_ready, busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_ignored_idle got rdy=%0b done=%0b exp 1 0", in_ready, done); end
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        accept(16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_valid !== 1'b1 || out_idx !== 4'(i)) begin errors++; $display("FAIL full_idx%0d got v=%0b idx=%0d exp v=1 idx=%0d", i, out_valid, out_idx, i); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (done !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL full_done got done=%0b count=%0d exp 1 16", done, count); end
        step();
    endtask

    task automatic test_mid_reset();
        int done_seen = 0;
        out_ready = 1'b0;
        accept(16'h00F0);
        checks++; if (out_valid !== 1'b1 || out_idx !== 4'd4) begin errors++; $display("FAIL rst_pre got v=%0b idx=%0d exp v=1 idx=4", out_valid, out_idx); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_idx !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async got v=%0b idx=%0d busy=%0b exp 0 0 0", out_valid, out_idx, busy); end
        checks++; if (in_ready !== 1'b1 || done !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL rst_async2 got rdy=%0b done=%0b count=%0d exp 1 0 0", in_ready, done, count); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (done !== 1'b0) done_seen++;
            step();
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_no_done got %0d pulses exp 0", done_seen); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_release got rdy=%0b v=%0b exp 1 0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_vec   = 16'h0003;
        in_valid = 1'b1;
        step();
        in_vec = 16'h0F00;
        checks++; if (out_idx !== 4'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_idx0 got idx=%0d rdy=%0b exp 0 0", out_idx, in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_idx !== 4'd1) begin errors++; $display("FAIL b2b_idx1 got v=%0b idx=%0d exp 1 1", out_valid, out_idx); end
        step();
        checks++; if (done !== 1'b1 || count !== 5'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done got done=%0b count=%0d rdy=%0b exp 1 2 0", done, count, in_ready); end
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 5'd2) begin errors++; $display("FAIL b2b_idle got rdy=%0b v=%0b count=%0d exp 1 0 2", in_ready, out_valid, count); end
    endtask

    initial begin
        test_reset();
        test_zero_vector();
        test_sparse();
        test_backpressure();
        test_abort();
        test_full();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
